second_game_sequencer: RTL and testbench

- Session controller for the second (obstacle-dodge) game engine.
- Owns the game lifecycle: idle, engine restart, countdown, run, pause and game-over.
- Generates the engine's pause/step/restart controls and a speed schedule that shortens the obstacle step period as play continues.
- Keeps the score for the HUD. Sits between the button/VGA-timing logic and the engine instance.

---
 rtl/second_game_pkg.sv | 16 +
 rtl/second_game_step_timer.sv | 72 +++++++
 rtl/second_game_sequencer.sv | 148 ++++++++++++++
 tb/tb_second_game_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/second_game_pkg.sv
// Shared state encoding and widths for the obstacle-dodge session controller.
package second_game_pkg;

    localparam int PERIOD_W  = 20;
    localparam int LEVEL_MAX = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESTART   = 3'd1,
        COUNTDOWN = 3'd2,
        RUN       = 3'd3,
        PAUSED    = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

endpackage

// File: rtl/second_game_step_timer.sv
// Obstacle step timer: period counter, step pulse and the level/speed schedule.
module second_game_step_timer
    import second_game_pkg::*;
#(
    parameter int STEP_PERIOD_INIT = 262144,
    parameter int STEP_PERIOD_MIN  = 65536,
    parameter int STEP_PERIOD_DEC  = 16384,
    parameter int LEVEL_STEPS      = 600
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       enable,
    input  logic       reload,
    output logic       step_due,
    output logic       step,
    output logic [3:0] level
);

    localparam int LSTEP_W = $clog2(LEVEL_STEPS + 1);
    localparam logic [PERIOD_W-1:0] P_INIT = PERIOD_W'(STEP_PERIOD_INIT);
    localparam logic [PERIOD_W-1:0] P_MIN  = PERIOD_W'(STEP_PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] P_ONE  = PERIOD_W'(1);
    localparam logic signed [PERIOD_W:0] DEC_S = (PERIOD_W + 1)'(STEP_PERIOD_DEC);
    localparam logic signed [PERIOD_W:0] MIN_S = (PERIOD_W + 1)'(STEP_PERIOD_MIN);

    logic [PERIOD_W-1:0]        cnt;
    logic [PERIOD_W-1:0]        period;
    logic [PERIOD_W-1:0]        next_period;
    logic [LSTEP_W-1:0]         lvl_cnt;
    logic signed [PERIOD_W:0]   period_dec;
    logic                       level_up;

    assign step_due = enable && (cnt == period - P_ONE);
    assign level_up = step_due && (lvl_cnt == LSTEP_W'(LEVEL_STEPS - 1));

    // Signed one-bit-wider subtraction so the clamp sees negative results instead of a wrap.
    assign period_dec  = $signed({1'b0, period}) - DEC_S;
    assign next_period = (period_dec < MIN_S) ? P_MIN : period_dec[PERIOD_W-1:0];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt     <= '0;
            period  <= P_INIT;
            lvl_cnt <= '0;
            level   <= '0;
            step    <= 1'b0;
        end else if (reload) begin
            cnt     <= '0;
            period  <= P_INIT;
            lvl_cnt <= '0;
            level   <= '0;
            step    <= 1'b0;
        end else begin
            step <= step_due;
            if (enable) begin
                cnt <= step_due ? '0 : cnt + P_ONE;
            end
            if (step_due) begin
                if (level_up) begin
                    lvl_cnt <= '0;
                    period  <= next_period;
                    if (level != 4'(LEVEL_MAX)) begin
                        level <= level + 4'd1;
                    end
                end else begin
                    lvl_cnt <= lvl_cnt + LSTEP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/second_game_sequencer.sv
// Session controller for the second game engine: lifecycle FSM, engine controls and score.
// Optional best-score register enabled by defining SECOND_GAME_BEST_SCORE_EN.
//
// state     | meaning
// IDLE      | waiting for start, engine paused
// RESTART   | engine restart held low for RESTART_CYCLES
// COUNTDOWN | counting frames before play
// RUN       | engine running, steps generated
// PAUSED    | engine frozen, timer phase held
// GAME_OVER | score frozen, start accepted after GAMEOVER_FRAMES
module second_game_sequencer
    import second_game_pkg::*;
#(
    parameter int STEP_PERIOD_INIT = 262144,
    parameter int STEP_PERIOD_MIN  = 65536,
    parameter int STEP_PERIOD_DEC  = 16384,
    parameter int LEVEL_STEPS      = 600,
    parameter int RESTART_CYCLES   = 4,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int GAMEOVER_FRAMES  = 120,
    parameter int SCORE_W          = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_start,
    input  logic               i_pause_toggle,
    input  logic               i_engine_lose,
    input  logic               i_frame_start,
    output logic               o_engine_rst_n,
    output logic               o_is_pause,
    output logic               o_step,
    output logic [2:0]         o_state,
    output logic [3:0]         o_level,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_best_score
);

    localparam int FRAME_MAX = (COUNTDOWN_FRAMES > GAMEOVER_FRAMES) ? COUNTDOWN_FRAMES : GAMEOVER_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int RST_W     = $clog2(RESTART_CYCLES + 1);

    state_t             state;
    state_t             state_next;
    logic [RST_W-1:0]   rst_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               gameover_done;
    logic               reload;
    logic               timer_en;
    logic               step_due;

    assign gameover_done = (frame_cnt == FRAME_W'(GAMEOVER_FRAMES));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        o_engine_rst_n = 1'b1;
        o_is_pause     = 1'b1;
        timer_en       = 1'b0;
        case (state)
            IDLE:      if (i_start) state_next = RESTART;
            RESTART: begin
                o_engine_rst_n = 1'b0;
                if (rst_cnt == RST_W'(RESTART_CYCLES - 1)) state_next = COUNTDOWN;
            end
            COUNTDOWN: if (i_frame_start && frame_cnt == FRAME_W'(COUNTDOWN_FRAMES - 1)) state_next = RUN;
            RUN: begin
                o_is_pause = 1'b0;
                // Lose wins over pause; a due step in a leaving cycle is dropped.
                timer_en   = !i_engine_lose && !i_pause_toggle;
                if (i_engine_lose)       state_next = GAME_OVER;
                else if (i_pause_toggle) state_next = PAUSED;
            end
            PAUSED: begin
                if (i_start)             state_next = RESTART;
                else if (i_pause_toggle) state_next = RUN;
            end
            GAME_OVER: if (gameover_done && i_start) state_next = RESTART;
            default:   state_next = IDLE;
        endcase
        reload = (state_next == RESTART) && (state != RESTART);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rst_cnt   <= '0;
            frame_cnt <= '0;
        end else if (state_next != state) begin
            rst_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (state == RESTART) rst_cnt <= rst_cnt + RST_W'(1);
            if (i_frame_start && (state == COUNTDOWN || (state == GAME_OVER && !gameover_done))) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_score <= '0;
        end else if (reload) begin
            o_score <= '0;
        end else if (step_due && (o_score != '1)) begin
            o_score <= o_score + SCORE_W'(1);
        end
    end

`ifdef SECOND_GAME_BEST_SCORE_EN
    logic [SCORE_W-1:0] best_score;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            best_score <= '0;
        end else if (state == RUN && state_next == GAME_OVER && o_score > best_score) begin
            best_score <= o_score;
        end
    end

    assign o_best_score = best_score;
`else
    assign o_best_score = '0;
`endif

    assign o_state = state;

    second_game_step_timer #(
        .STEP_PERIOD_INIT (STEP_PERIOD_INIT),
        .STEP_PERIOD_MIN  (STEP_PERIOD_MIN),
        .STEP_PERIOD_DEC  (STEP_PERIOD_DEC),
        .LEVEL_STEPS      (LEVEL_STEPS)
    ) u_step_timer (
        .clk      (clk),
        .arst_n   (arst_n),
        .enable   (timer_en),
        .reload   (reload),
        .step_due (step_due),
        .step     (o_step),
        .level    (o_level)
    );

endmodule

// File: tb/tb_second_game_sequencer.sv
// Bench for second_game_sequencer: directed session flows plus random play against a behavioural model.
module tb_second_game_sequencer;
    import second_game_pkg::*;

    localparam int INIT = 8, PMIN = 4, DEC = 2, LSTEPS = 3, RC = 4, CD = 2, GO = 2;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        i_start = 1'b0, i_pause_toggle = 1'b0, i_engine_lose = 1'b0, i_frame_start = 1'b0;
    logic        o_engine_rst_n, o_is_pause, o_step;
    logic [2:0]  o_state;
    logic [3:0]  o_level;
    logic [15:0] o_score, o_best_score;

    int checks = 0;
    int errors = 0;

    // Behavioural model: session described in terms of elapsed cycles and step counts.
    state_t m_state;
    int m_rst_left, m_frames, m_elapsed, m_period, m_lvl_steps, m_level, m_score, m_best;
    logic m_step;

    second_game_sequencer #(
        .STEP_PERIOD_INIT(INIT), .STEP_PERIOD_MIN(PMIN), .STEP_PERIOD_DEC(DEC),
        .LEVEL_STEPS(LSTEPS), .RESTART_CYCLES(RC), .COUNTDOWN_FRAMES(CD),
        .GAMEOVER_FRAMES(GO), .SCORE_W(16)
    ) dut (
        .clk(clk), .arst_n(arst_n), .i_start(i_start), .i_pause_toggle(i_pause_toggle),
        .i_engine_lose(i_engine_lose), .i_frame_start(i_frame_start),
        .o_engine_rst_n(o_engine_rst_n), .o_is_pause(o_is_pause), .o_step(o_step),
        .o_state(o_state), .o_level(o_level), .o_score(o_score), .o_best_score(o_best_score)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = IDLE; m_rst_left = 0; m_frames = 0; m_elapsed = 0; m_period = INIT;
        m_lvl_steps = 0; m_level = 0; m_score = 0; m_best = 0; m_step = 1'b0;
    endtask

    task automatic m_enter_restart();
        m_state = RESTART; m_rst_left = RC; m_score = 0; m_level = 0;
        m_period = INIT; m_elapsed = 0; m_lvl_steps = 0;
    endtask

    task automatic m_advance();
        logic st, tg, ls, fr;
        st = i_start; tg = i_pause_toggle; ls = i_engine_lose; fr = i_frame_start;
        m_step = 1'b0;
        case (m_state)
            IDLE: if (st) m_enter_restart();
            RESTART: begin
                m_rst_left--;
                if (m_rst_left == 0) begin m_state = COUNTDOWN; m_frames = 0; end
            end
            COUNTDOWN: if (fr) begin
                m_frames++;
                if (m_frames == CD) m_state = RUN;
            end
            RUN: begin
                if (ls) begin
                    if (m_score > m_best) m_best = m_score;
                    m_state = GAME_OVER; m_frames = 0;
                end else if (tg) begin
                    m_state = PAUSED;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == m_period) begin
                        m_elapsed = 0; m_step = 1'b1;
                        if (m_score < 65535) m_score++;
                        m_lvl_steps++;
                        if (m_lvl_steps == LSTEPS) begin
                            m_lvl_steps = 0;
                            if (m_level < 15) m_level++;
                            m_period = (m_period - DEC < PMIN) ? PMIN : m_period - DEC;
                        end
                    end
                end
            end
            PAUSED: begin
                if (st)      m_enter_restart();
                else if (tg) m_state = RUN;
            end
            GAME_OVER: begin
                if (m_frames >= GO && st) m_enter_restart();
                else if (fr)              m_frames++;
            end
            default: m_state = IDLE;
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) m_reset();
            else         m_advance();
        end
    end

    function automatic int exp_best();
`ifdef SECOND_GAME_BEST_SCORE_EN
        return m_best;
`else
        return 0;
`endif
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            check("state",      int'(o_state),        int'(m_state));
            check("engine_rst", int'(o_engine_rst_n), (m_state == RESTART) ? 0 : 1);
            check("is_pause",   int'(o_is_pause),     (m_state == RUN) ? 0 : 1);
            check("step",       int'(o_step),         int'(m_step));
            check("level",      int'(o_level),        m_level);
            check("score",      int'(o_score),        m_score);
            check("best",       int'(o_best_score),   exp_best());
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1 i_frame_start = 1'b1;
        @(posedge clk); #1 i_frame_start = 1'b0;
    endtask

    task automatic pulse_toggle();
        @(posedge clk); #1 i_pause_toggle = 1'b1;
        @(posedge clk); #1 i_pause_toggle = 1'b0;
    endtask

    // Counts negedges up to and including the one showing o_step; bounded.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_step && n < 200);
    endtask

    task automatic enter_run();
        repeat (RC + 2) @(negedge clk);
        pulse_frame();
        pulse_frame();
        @(negedge clk);
        check("run_entered", int'(o_state), int'(RUN));
    endtask

    initial begin
        int n;
        int exp_gap[8];
        exp_gap = '{8, 6, 6, 6, 4, 4, 4, 4};
        #2 arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        @(negedge clk);
        check("rst_state", int'(o_state), 0);
        check("rst_pause", int'(o_is_pause), 1);
        check("rst_engine", int'(o_engine_rst_n), 1);
        check("rst_score", int'(o_score), 0);

        // Start flow: restart width, countdown, first step latency.
        pulse_start();
        n = 0;
        repeat (RC + 4) begin
            @(negedge clk);
            if (!o_engine_rst_n) n++;
        end
        check("restart_cycles", n, 4);
        pulse_frame();
        pulse_frame();
        @(negedge clk);
        check("run_state", int'(o_state), 3);
        check("run_unpause", int'(o_is_pause), 0);
        wait_step(n);
        check("first_step_gap", n, 8);
        check("score_after_1", int'(o_score), 1);

        // Pause three cycles into an interval, resume, remaining 5 cycles.
        repeat (3) @(posedge clk);
        #1 i_pause_toggle = 1'b1;
        @(posedge clk); #1 i_pause_toggle = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_step) n++;
        end
        check("steps_while_paused", n, 0);
        check("score_paused", int'(o_score), 1);
        pulse_toggle();
        @(negedge clk);
        check("resumed_state", int'(o_state), 3);
        wait_step(n);
        check("resume_gap", n, 5);
        check("score_after_2", int'(o_score), 2);

        // Speed ramp through the clamp.
        for (int i = 0; i < 8; i++) begin
            wait_step(n);
            check($sformatf("gap_step%0d", i + 3), n, exp_gap[i]);
            if (i == 0) check("level_after_3", int'(o_level), 1);
            if (i == 6) check("level_after_9", int'(o_level), 3);
        end
        check("score_after_10", int'(o_score), 10);

        // Lose on the cycle a step is due.
        repeat (3) @(posedge clk);
        #1 i_engine_lose = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lose_state", int'(o_state), 5);
        check("lose_no_step", int'(o_step), 0);
        check("lose_score", int'(o_score), 10);
        @(posedge clk); #1 i_engine_lose = 1'b0;
        pulse_start();
        @(negedge clk);
        check("go_start_ignored0", int'(o_state), 5);
        pulse_frame();
        pulse_start();
        @(negedge clk);
        check("go_start_ignored1", int'(o_state), 5);
        pulse_frame();
        pulse_start();
        @(negedge clk);
        check("go_restart", int'(o_state), 1);
        check("go_restart_score", int'(o_score), 0);

        // Asynchronous reset mid-RUN.
        enter_run();
        repeat (10) @(negedge clk);
        @(posedge clk); #1 arst_n = 1'b0;
        #1;
        check("arst_state", int'(o_state), 0);
        check("arst_score", int'(o_score), 0);
        check("arst_pause", int'(o_is_pause), 1);
        check("arst_level", int'(o_level), 0);
        @(posedge clk); #1 arst_n = 1'b1;

        // Session scoring 5, then one scoring 3 ended by lose+pause together.
        pulse_start();
        enter_run();
        repeat (5) wait_step(n);
        @(posedge clk); #1 i_engine_lose = 1'b1;
        @(posedge clk); #1 i_engine_lose = 1'b0;
        @(negedge clk);
        check("s5_state", int'(o_state), 5);
        check("s5_score", int'(o_score), 5);
`ifdef SECOND_GAME_BEST_SCORE_EN
        check("s5_best", int'(o_best_score), 5);
`else
        check("s5_best", int'(o_best_score), 0);
`endif
        pulse_frame();
        pulse_frame();
        pulse_start();
        enter_run();
        repeat (3) wait_step(n);
        @(posedge clk); #1 i_engine_lose = 1'b1; i_pause_toggle = 1'b1;
        @(posedge clk); #1 i_engine_lose = 1'b0; i_pause_toggle = 1'b0;
        @(negedge clk);
        check("lose_pause_state", int'(o_state), 5);
        check("s3_score", int'(o_score), 3);
`ifdef SECOND_GAME_BEST_SCORE_EN
        check("s3_best", int'(o_best_score), 5);
`else
        check("s3_best", int'(o_best_score), 0);
`endif

        // Random play, checked every cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            i_start        = ($urandom_range(0, 39) == 0);
            i_pause_toggle = ($urandom_range(0, 29) == 0);
            i_frame_start  = ($urandom_range(0, 3) == 0);
            if (i_engine_lose) i_engine_lose = ($urandom_range(0, 2) != 0);
            else               i_engine_lose = ($urandom_range(0, 79) == 0);
        end
        @(posedge clk); #1;
        i_start = 1'b0; i_pause_toggle = 1'b0; i_frame_start = 1'b0; i_engine_lose = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
